// File: rtl/pc_control.sv
// Fetch PC sequencer: BOOT/RUN/HALTED control, JR/J/branch redirect selection,
// sticky misaligned-JR flag and a count of PC advances.
module pc_control #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] shift_out,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        stall,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target,
  output logic        running,
  output logic        addr_err,
  output logic [31:0] instr_count
);

  // state  | meaning
  // BOOT   | single cycle after reset, pc held at RESET_PC
  // RUN    | fetching; pc advances unless stalled
  // HALTED | everything frozen until reset
  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] count_nxt;
  logic        err_nxt;
  logic [31:0] jr_target;
  logic [31:0] jump_target;

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + shift_out;
  assign jr_target     = {jr_addr[31:2], 2'b00};
  assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};
  assign running       = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      instr_count <= '0;
      addr_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr_count <= count_nxt;
      addr_err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    count_nxt = instr_count;
    err_nxt   = addr_err;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        // halt wins over stall; a stalled cycle ignores redirects entirely
        if (halt) begin
          state_nxt = HALTED;
        end else if (!stall) begin
          count_nxt = instr_count + 32'd1;
          if (jr) begin
            pc_nxt = jr_target;
            if (jr_addr[1:0] != 2'b00) err_nxt = 1'b1;
          end else if (jump) begin
            pc_nxt = jump_target;
          end else if (branch_taken) begin
            pc_nxt = branch_target;
          end else begin
            pc_nxt = pc_plus4;
          end
        end
      end
      HALTED: state_nxt = HALTED;
      default: state_nxt = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_control.sv
// Scoreboard bench for pc_control: driver pushes model expectations, monitor
// compares them after each clock edge or asynchronous reset event.
module tb_pc_control;
  logic        clk;
  logic        rst_n;
  logic [31:0] shift_out;
  logic        branch_taken;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_addr;
  logic        stall;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic        running;
  logic        addr_err;
  logic [31:0] instr_count;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  pc_control #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .shift_out(shift_out), .branch_taken(branch_taken),
    .jump(jump), .jump_index(jump_index), .jr(jr), .jr_addr(jr_addr),
    .stall(stall), .halt(halt), .pc(pc), .pc_plus4(pc_plus4),
    .branch_target(branch_target), .running(running), .addr_err(addr_err),
    .instr_count(instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] p4;
    logic [31:0] bt;
    logic [31:0] cnt;
    logic        run;
    logic        err;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   checks = 0;
  int   failures = 0;
  int   item_no = 0;

  // reference model: mode 0 = booting, 1 = running, 2 = halted
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_err;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s item=%0d actual=%h expected=%h", name, item_no, act, exp);
    end
  endfunction

  function automatic void push_expect();
    exp_t e;
    e.pc  = m_pc;
    e.p4  = m_pc + 32'd4;
    e.bt  = m_pc + 32'd4 + shift_out;
    e.cnt = m_cnt;
    e.run = (m_mode == 1);
    e.err = m_err;
    q.push_back(e);
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        item_no++;
        chk("mon_pc", pc, e.pc);
        chk("mon_pc_plus4", pc_plus4, e.p4);
        chk("mon_branch_target", branch_target, e.bt);
        chk("mon_instr_count", instr_count, e.cnt);
        chk("mon_running", {31'd0, running}, {31'd0, e.run});
        chk("mon_addr_err", {31'd0, addr_err}, {31'd0, e.err});
      end
    end
  end

  task automatic step(input logic br, input logic j, input logic [25:0] idx,
                      input logic r, input logic [31:0] ra, input logic [31:0] off,
                      input logic st, input logic h);
    logic [31:0] p4;
    @(negedge clk);
    branch_taken = br; jump = j; jump_index = idx; jr = r; jr_addr = ra;
    shift_out = off; stall = st; halt = h;
    p4 = m_pc + 32'd4;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (h) m_mode = 2;
      else if (!st) begin
        if (r) begin
          m_pc = ra & ~32'd3;
          if (ra % 4 != 0) m_err = 1'b1;
        end else if (j) m_pc = {p4[31:28], idx, 2'b00};
        else if (br) m_pc = p4 + off;
        else m_pc = p4;
        m_cnt = m_cnt + 32'd1;
      end
    end
    push_expect();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 26'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic jr_to(input logic [31:0] a);
    step(1'b0, 1'b0, 26'd0, 1'b1, a, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // reset asserted between edges; outputs must change without a clock
  task automatic reset_pulse();
    @(posedge clk);
    #2 rst_n = 1'b0;
    m_mode = 0; m_pc = RST_PC; m_cnt = '0; m_err = 1'b0;
    #1 push_expect();
    -> chk_ev;
    #3 rst_n = 1'b1;
  endtask

  initial begin
    logic br, j, r, st, h;
    logic [31:0] ra, off;
    rst_n = 1'b0;
    shift_out = '0; branch_taken = 1'b0; jump = 1'b0; jump_index = '0;
    jr = 1'b0; jr_addr = '0; stall = 1'b0; halt = 1'b0;
    reset_pulse();

    // boot then two sequential advances: pc 0,0,4,8 and count 2
    repeat (3) idle();
    after_edge();
    chk("boot_seq_pc", pc, 32'h8);
    chk("boot_seq_count", instr_count, 32'd2);

    jr_to(32'h0000_0010);
    step(1'b1, 1'b0, 26'd0, 1'b0, 32'd0, 32'hFFFF_FFF0, 1'b0, 1'b0);
    #1 chk("branch_target_back", branch_target, 32'h0000_0004);
    after_edge();
    chk("branch_back_pc", pc, 32'h0000_0004);

    jr_to(32'h4000_0008);
    step(1'b1, 1'b1, 26'h0000040, 1'b0, 32'd0, 32'h0000_0100, 1'b0, 1'b0);
    after_edge();
    chk("jump_over_branch_pc", pc, 32'h4000_0100);

    jr_to(32'hFFFF_FFFC);
    idle();
    after_edge();
    chk("pc_wrap", pc, 32'h0000_0000);

    jr_to(32'h0000_0123);
    after_edge();
    chk("jr_misaligned_pc", pc, 32'h0000_0120);
    chk("jr_misaligned_err", {31'd0, addr_err}, 32'd1);
    repeat (10) idle();
    after_edge();
    chk("err_sticky", {31'd0, addr_err}, 32'd1);

    jr_to(32'h0000_0020);
    repeat (3) step(1'b1, 1'b1, 26'h3FF_FFFF, 1'b1, 32'h0000_1000, 32'h40, 1'b1, 1'b0);
    after_edge();
    chk("stall_pc", pc, 32'h0000_0020);
    step(1'b0, 1'b0, 26'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0, 26'd0, 1'b1, 32'h0000_0777, 32'd8, 1'b0, 1'b0);
    after_edge();
    chk("halted_pc", pc, 32'h0000_0020);
    chk("halted_running", {31'd0, running}, 32'd0);

    reset_pulse();
    idle();
    idle();
    after_edge();
    chk("post_reset_pc", pc, RST_PC + 32'd4);

    for (int i = 0; i < 600; i++) begin
      br  = ($urandom % 3) == 0;
      j   = ($urandom % 5) == 0;
      r   = ($urandom % 6) == 0;
      ra  = $urandom;
      if (($urandom % 8) != 0) ra[1:0] = 2'b00;
      off = $urandom;
      off = {{14{off[15]}}, off[15:0], 2'b00};
      st  = ($urandom % 5) == 0;
      h   = ($urandom % 60) == 0;
      step(br, j, 26'($urandom), r, ra, off, st, h);
      if ((m_mode == 2 && ($urandom % 4) == 0) || (i % 97) == 96) reset_pulse();
    end

    @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
